// File: rtl/ft_pkg.sv
// Shared types and constants for the lockstep recovery controller.
package ft_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        RESTORE = 3'd2,
        SET_PC  = 3'd3,
        RESUME  = 3'd4
    } recovery_state_e;

    localparam int unsigned CNT_W = 32'd8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/ft_shadow_rf.sv
// Shadow copy of the golden register file: one write port, one combinational
// read port, and a per-entry valid bitmap with synchronous clear.
module ft_shadow_rf #(
    parameter int unsigned ADDR_WIDTH = 32'd5,
    parameter int unsigned DATA_WIDTH = 32'd32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [DEPTH-1:0]      wr_mask_s;
    logic [DEPTH-1:0]      valid_n_s;

    // A write in the same cycle as a clear survives: it belongs to the next recovery.
    always_comb begin
        wr_mask_s = {{(DEPTH-1){1'b0}}, we_i} << waddr_i;
        valid_n_s = (clr_i ? {DEPTH{1'b0}} : valid_r) | wr_mask_s;
    end

    // Data storage, last write to an index wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 32'd0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    // Valid bitmap register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= {DEPTH{1'b0}};
        end else begin
            valid_r <= valid_n_s;
        end
    end

    assign rdata_o  = mem_r[raddr_i];
    assign rvalid_o = valid_r[raddr_i];

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Recovery sequencer: captures the golden state streamed by ft_module, halts
// both lockstep cores, replays the registers and PC into them, then releases.
module ft_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32'd5,
    parameter int unsigned DATA_WIDTH    = 32'd32,
    parameter int unsigned DRAIN_TIMEOUT = 32'd64,
    parameter bit          SKIP_X0       = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_block_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    input  logic                  core_idle_i,
    output logic                  halt_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  pc_set_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [CNT_W-1:0]      recovery_cnt_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned TMR_W = $clog2(DRAIN_TIMEOUT + 32'd1);

    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_MAX  = ADDR_WIDTH'(DEPTH - 32'd1);
    localparam logic [TMR_W-1:0]      TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0]      TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 32'd1);

    recovery_state_e       state_r, state_n_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_n_s;
    logic [TMR_W-1:0]      drain_cnt_r, drain_cnt_n_s;
    logic                  expired_s;
    logic                  pending_r, pending_n_s;
    logic                  clr_valid_s;
    logic                  rf_we_n_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  rd_valid_s;
    logic [DATA_WIDTH-1:0] pc_latch_r;

    logic                  halt_r;
    logic                  busy_r;
    logic                  rf_we_r;
    logic [ADDR_WIDTH-1:0] rf_addr_r;
    logic [DATA_WIDTH-1:0] rf_wdata_r;
    logic                  pc_set_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic                  timeout_r;
    logic [CNT_W-1:0]      recovery_cnt_r;

    // The shadow is read at the upcoming sweep index so replay outputs can be registered.
    ft_shadow_rf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_valid_s),
        .we_i     (fetch_block_i),
        .waddr_i  (addr_i),
        .wdata_i  (data_i),
        .raddr_i  (idx_n_s),
        .rdata_o  (rd_data_s),
        .rvalid_o (rd_valid_s)
    );

    // Next-state logic for the recovery sequence.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (fetch_block_i) state_n_s = DRAIN;
                else               state_n_s = IDLE;
            end
            DRAIN: begin
                if (!fetch_block_i && (core_idle_i || expired_s)) state_n_s = RESTORE;
                else                                               state_n_s = DRAIN;
            end
            RESTORE: begin
                if (idx_r == IDX_MAX) state_n_s = SET_PC;
                else                  state_n_s = RESTORE;
            end
            SET_PC: state_n_s = RESUME;
            RESUME: begin
                if (pending_r || fetch_block_i) state_n_s = DRAIN;
                else                            state_n_s = IDLE;
            end
            default: state_n_s = IDLE;
        endcase
    end

    // Sweep index, drain timer, pending request and replay write qualification.
    always_comb begin
        expired_s     = (drain_cnt_r >= TMR_LAST);
        idx_n_s       = (state_r == RESTORE) ? (idx_r + IDX_ONE) : IDX_ZERO;
        drain_cnt_n_s = TMR_ZERO;
        if (state_r == DRAIN) begin
            drain_cnt_n_s = expired_s ? drain_cnt_r : (drain_cnt_r + TMR_ONE);
        end else begin
            drain_cnt_n_s = TMR_ZERO;
        end
        pending_n_s = pending_r;
        if ((state_n_s == DRAIN) && (state_r != DRAIN)) begin
            pending_n_s = 1'b0;
        end else if (fetch_block_i && ((state_r == RESTORE) || (state_r == SET_PC))) begin
            pending_n_s = 1'b1;
        end else begin
            pending_n_s = pending_r;
        end
        // Cores stay halted across a back-to-back recovery, so entries already replayed
        // are still correct in the cores; keep the bitmap so new captures are not lost.
        clr_valid_s = (state_r == RESUME) && !pending_r;
        rf_we_n_s   = (state_n_s == RESTORE) && rd_valid_s &&
                      !(SKIP_X0 && (idx_n_s == IDX_ZERO));
    end

    // Sequencer state and capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            idx_r       <= IDX_ZERO;
            drain_cnt_r <= TMR_ZERO;
            pending_r   <= 1'b0;
            pc_latch_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_n_s;
            idx_r       <= idx_n_s;
            drain_cnt_r <= drain_cnt_n_s;
            pending_r   <= pending_n_s;
            if (fetch_block_i) begin
                pc_latch_r <= spc_i;
            end
        end
    end

    // Registered outputs, derived from the state being entered so they align with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_r         <= 1'b0;
            busy_r         <= 1'b0;
            rf_we_r        <= 1'b0;
            rf_addr_r      <= IDX_ZERO;
            rf_wdata_r     <= {DATA_WIDTH{1'b0}};
            pc_set_r       <= 1'b0;
            pc_r           <= {DATA_WIDTH{1'b0}};
            timeout_r      <= 1'b0;
            recovery_cnt_r <= {CNT_W{1'b0}};
        end else begin
            halt_r     <= (state_n_s != IDLE);
            busy_r     <= (state_n_s != IDLE);
            rf_we_r    <= rf_we_n_s;
            rf_addr_r  <= (state_n_s == RESTORE) ? idx_n_s : IDX_ZERO;
            rf_wdata_r <= (state_n_s == RESTORE) ? rd_data_s : {DATA_WIDTH{1'b0}};
            pc_set_r   <= (state_n_s == SET_PC);
            if (state_n_s == SET_PC) begin
                pc_r <= pc_latch_r;
            end
            timeout_r <= timeout_r | ((state_r == DRAIN) && expired_s && !core_idle_i);
            if (state_r == RESUME) begin
                recovery_cnt_r <= sat_inc(recovery_cnt_r);
            end
        end
    end

    assign halt_o         = halt_r;
    assign busy_o         = busy_r;
    assign rf_we_o        = rf_we_r;
    assign rf_addr_o      = rf_addr_r;
    assign rf_wdata_o     = rf_wdata_r;
    assign pc_set_o       = pc_set_r;
    assign pc_o           = pc_r;
    assign timeout_o      = timeout_r;
    assign recovery_cnt_o = recovery_cnt_r;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed bench for ft_recovery_ctrl with a scoreboard of expected register
// replays and PC loads, checked every cycle against the DUT outputs.
module tb_ft_recovery_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_block = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] spc = '0;
    logic          core_idle = 1'b0;

    logic          halt_o, rf_we_o, pc_set_o, busy_o, timeout_o;
    logic [AW-1:0] rf_addr_o;
    logic [DW-1:0] rf_wdata_o, pc_o;
    logic [7:0]    recovery_cnt_o;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int pc_set_cyc = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    pc_q[$];

    always #5 clk = ~clk;

    ft_recovery_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .DRAIN_TIMEOUT (64),
        .SKIP_X0       (1'b1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fetch_block_i  (fetch_block),
        .addr_i         (addr),
        .data_i         (data),
        .spc_i          (spc),
        .core_idle_i    (core_idle),
        .halt_o         (halt_o),
        .rf_we_o        (rf_we_o),
        .rf_addr_o      (rf_addr_o),
        .rf_wdata_o     (rf_wdata_o),
        .pc_set_o       (pc_set_o),
        .pc_o           (pc_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o),
        .recovery_cnt_o (recovery_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [AW+DW-1:0] e;
        logic [DW-1:0]    p;
        if (rf_we_o === 1'b1) begin
            last_we_cyc = cyc;
            chk("halt_during_write", 64'(halt_o), 64'd1);
            chk("rf_write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rf_write", 64'({rf_addr_o, rf_wdata_o}), 64'(e));
            end
        end
        if (pc_set_o === 1'b1) begin
            pc_set_cyc = cyc;
            chk("pc_set_expected", 64'(pc_q.size() != 0), 64'd1);
            if (pc_q.size() != 0) begin
                p = pc_q.pop_front();
                chk("pc_value", 64'(pc_o), 64'(p));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic stream(input int a, input int d, input logic [DW-1:0] p);
        fetch_block = 1'b1;
        addr        = AW'(a);
        data        = DW'(d);
        spc         = p;
        if (a != 0) exp_q.push_back({AW'(a), DW'(d)});
        tick();
        fetch_block = 1'b0;
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while (busy_o === 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("reached_idle", 64'(busy_o), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int gap;
        int n;

        // Reset state held with no requests
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("reset_outputs_zero",
                64'({halt_o, rf_we_o, rf_addr_o, rf_wdata_o, pc_set_o, pc_o,
                     busy_o, timeout_o, recovery_cnt_o}), 64'd0);
        end

        // Full register file stream, x0 never replayed
        core_idle = 1'b1;
        for (int i = 0; i < 32; i++) begin
            stream(i, i * 10, 32'h80);
            if (i == 0) chk("halt_asserted", 64'(halt_o), 64'd1);
        end
        pc_q.push_back(32'h80);
        run_until_idle(200);
        chk("full_halt_released", 64'(halt_o), 64'd0);
        chk("full_cnt", 64'(recovery_cnt_o), 64'd1);
        chk("full_writes_done", 64'(exp_q.size()), 64'd0);
        chk("full_pc_done", 64'(pc_q.size()), 64'd0);
        chk("full_pc_o", 64'(pc_o), 64'h80);
        chk("full_last_write_to_pc_set", 64'(pc_set_cyc - last_we_cyc), 64'd1);
        chk("full_no_timeout", 64'(timeout_o), 64'd0);

        // Single entry: one write, sweep still covers all 32 indices
        stream(10, 100, 32'h80);
        pc_q.push_back(32'h80);
        run_until_idle(200);
        chk("single_writes_done", 64'(exp_q.size()), 64'd0);
        chk("single_pc_done", 64'(pc_q.size()), 64'd0);
        chk("single_restore_len", 64'(pc_set_cyc - last_we_cyc), 64'd22);
        chk("single_cnt", 64'(recovery_cnt_o), 64'd2);

        // Cores never drain: forced restore after the timeout
        core_idle = 1'b0;
        stream(3, 33, 32'h100);
        pc_q.push_back(32'h100);
        repeat (63) tick();
        chk("drain_pre_timeout", 64'({timeout_o, busy_o}), 64'b01);
        tick();
        chk("drain_timeout_set", 64'(timeout_o), 64'd1);
        run_until_idle(200);
        chk("timeout_sticky", 64'(timeout_o), 64'd1);
        chk("timeout_cnt", 64'(recovery_cnt_o), 64'd3);
        chk("timeout_writes_done", 64'(exp_q.size()), 64'd0);
        chk("timeout_pc_done", 64'(pc_q.size()), 64'd0);
        do_reset();
        chk("timeout_cleared_by_reset", 64'({timeout_o, recovery_cnt_o}), 64'd0);

        // New request during RESTORE chains a second recovery with no IDLE gap
        core_idle = 1'b1;
        stream(5, 50, 32'h200);
        pc_q.push_back(32'h200);
        tick();
        repeat (10) tick();
        chk("chain_first_write_done", 64'(exp_q.size()), 64'd0);
        stream(5, 55, 32'h200);
        pc_q.push_back(32'h200);
        gap = 0;
        n = 0;
        while (pc_q.size() != 0 && n < 300) begin
            tick();
            if (busy_o !== 1'b1) gap = 1;
            n++;
        end
        chk("chain_both_pc_sets", 64'(pc_q.size()), 64'd0);
        chk("chain_no_idle_gap", 64'(gap), 64'd0);
        run_until_idle(50);
        chk("chain_writes_done", 64'(exp_q.size()), 64'd0);
        chk("chain_cnt", 64'(recovery_cnt_o), 64'd2);

        // Asynchronous reset in the middle of RESTORE
        do_reset();
        stream(12, 120, 32'h40);
        pc_q.push_back(32'h40);
        tick();
        repeat (4) tick();
        chk("mid_restore_busy", 64'({halt_o, busy_o}), 64'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_released", 64'({halt_o, rf_we_o, busy_o}), 64'd0);
        exp_q.delete();
        pc_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        stream(12, 120, 32'h40);
        pc_q.push_back(32'h40);
        run_until_idle(200);
        chk("post_rst_writes_done", 64'(exp_q.size()), 64'd0);
        chk("post_rst_pc_done", 64'(pc_q.size()), 64'd0);
        chk("post_rst_cnt", 64'(recovery_cnt_o), 64'd1);
        chk("post_rst_halt", 64'(halt_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
